// File: rtl/wb_spi_slave.sv
// wb_spi_slave: Wishbone classic front end for the SPI core with a 4-entry TX FIFO and sticky IRQ.
module wb_spi_slave #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_irq_o,
    output logic [10:0] core_din,
    output logic        core_cmd,
    output logic        core_wr,
    output logic        core_rd,
    input  logic [8:0]  core_dout,
    input  logic        core_ack,
    input  logic        core_irq
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_BUSACK = 2'd3;
    localparam logic [1:0] K_CMD = 2'd0, K_RD = 2'd1, K_WR = 2'd2;
    logic [1:0] state, kind, wp, rp;
    logic [7:0] cnt;
    logic [7:0] mem [4];
    logic [2:0] count;
    logic [10:0] din_q, shadow;
    logic [31:0] dat_q, status, rd_val;
    logic fast_ack, fast_err, aborted, tmo_hit, irq_q, irq_pend, irq_en, tmo_flag;
    logic req, core_req, fast_hit, empty, full, push, pop, expire, done, rise, st_wr, tx_wr;
    logic unused_dat;
    assign unused_dat = &{1'b0, wb_dat_i[31:11]};
    assign req = wb_cyc_i & wb_stb_i;
    // Only CTRL writes and RXDATA reads touch the core; everything else is answered locally.
    assign core_req = req & ((wb_adr_i == 2'd0 & wb_we_i) | (wb_adr_i == 2'd2 & ~wb_we_i));
    assign fast_hit = req & ~core_req & ~fast_ack & ~fast_err;
    assign st_wr = fast_hit & wb_we_i & wb_adr_i == 2'd3;
    assign tx_wr = fast_hit & wb_we_i & wb_adr_i == 2'd1;
    assign empty = count == 3'd0;
    assign full = count == 3'd4;
    assign push = tx_wr & ~full;
    assign expire = state == S_WAIT & ~core_ack & cnt == 8'(TIMEOUT - 1);
    assign done = state == S_WAIT & (core_ack | expire);
    assign pop = done & kind == K_WR;
    assign rise = core_irq & ~irq_q;
    assign status = {23'b0, irq_en, 1'b0, tmo_flag, irq_pend, count, full, empty};
    assign rd_val = wb_we_i ? 32'b0 : wb_adr_i == 2'd0 ? {21'b0, shadow} : wb_adr_i == 2'd3 ? status : 32'b0;
    assign core_cmd = state == S_ISSUE & kind == K_CMD;
    assign core_wr = state == S_ISSUE & kind == K_WR;
    assign core_rd = state == S_ISSUE & kind == K_RD;
    assign core_din = din_q;
    assign wb_ack_o = fast_ack | (state == S_BUSACK & ~aborted & ~tmo_hit);
    assign wb_err_o = fast_err | (state == S_BUSACK & ~aborted & tmo_hit);
    assign wb_dat_o = wb_ack_o ? dat_q : 32'b0;
    assign wb_irq_o = irq_pend & irq_en;
    always_ff @(posedge clk)
        if (push) mem[wp] <= wb_dat_i[7:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            kind <= K_CMD;
            cnt <= '0;
            wp <= '0;
            rp <= '0;
            count <= '0;
            din_q <= '0;
            shadow <= '0;
            dat_q <= '0;
            fast_ack <= 1'b0;
            fast_err <= 1'b0;
            aborted <= 1'b0;
            tmo_hit <= 1'b0;
            irq_q <= 1'b0;
            irq_pend <= 1'b0;
            irq_en <= 1'b0;
            tmo_flag <= 1'b0;
        end else begin
            fast_ack <= fast_hit & ~(tx_wr & full);
            fast_err <= tx_wr & full;
            irq_q <= core_irq;
            irq_pend <= rise | (irq_pend & ~(st_wr & wb_dat_i[5]));
            tmo_flag <= expire | (tmo_flag & ~(st_wr & wb_dat_i[6]));
            if (st_wr) irq_en <= wb_dat_i[8];
            if (fast_hit) dat_q <= rd_val;
            wp <= wp + 2'(push);
            rp <= rp + 2'(pop);
            count <= count + 3'(push) - 3'(pop);
            case (state)
                S_IDLE: begin
                    aborted <= 1'b0;
                    tmo_hit <= 1'b0;
                    if (core_req) begin
                        state <= S_ISSUE;
                        kind <= wb_adr_i == 2'd0 ? K_CMD : K_RD;
                        din_q <= wb_adr_i == 2'd0 ? wb_dat_i[10:0] : 11'b0;
                        if (wb_adr_i == 2'd0) shadow <= wb_dat_i[10:0];
                        dat_q <= '0;
                    end else if (!empty) begin
                        state <= S_ISSUE;
                        kind <= K_WR;
                        din_q <= {3'b0, mem[rp]};
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                    cnt <= '0;
                    if (!wb_cyc_i) aborted <= 1'b1;
                end
                S_WAIT: begin
                    if (!wb_cyc_i) aborted <= 1'b1;
                    if (done) begin
                        // Drains finish silently; bus accesses go through BUSACK.
                        state <= kind == K_WR ? S_IDLE : S_BUSACK;
                        tmo_hit <= expire;
                        if (core_ack && kind == K_RD) dat_q <= {23'b0, core_dout};
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_spi_slave.sv
// tb_wb_spi_slave: scoreboard bench; driver queues expected bus/core events, monitor checks them.
module tb_wb_spi_slave;
    localparam int TMO = 24;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [1:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic wb_ack_o, wb_err_o, wb_irq_o;
    logic [10:0] core_din;
    logic core_cmd, core_wr, core_rd;
    logic [8:0] core_dout = '0;
    logic core_ack = 1'b0, core_irq = 1'b0;
    logic core_stall = 1'b0, core_mute = 1'b0;
    int ack_dly = 1;
    int total = 0, bad = 0;
    logic [32:0] bq[$];
    logic [13:0] sq[$];
    localparam logic [2:0] CMD = 3'b100, WR = 3'b010, RD = 3'b001;

    wb_spi_slave #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .wb_irq_o(wb_irq_o), .core_din(core_din), .core_cmd(core_cmd),
        .core_wr(core_wr), .core_rd(core_rd), .core_dout(core_dout), .core_ack(core_ack),
        .core_irq(core_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a rising edge; returns likewise.
    task automatic wb_xfer(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                           input logic e_err, input logic [31:0] e_dat, input int e_lat);
        int n;
        bq.push_back({e_err, e_dat});
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        n = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb_ack_o || wb_err_o) && n < 400);
        check("bus_terminated", {63'b0, wb_ack_o | wb_err_o}, 64'd1);
        if (e_lat >= 0) check("bus_latency", 64'(n), 64'(e_lat));
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    // Core model: acks each strobe ack_dly cycles later unless stalled or muted.
    initial forever begin
        @(negedge clk);
        if (!rst && (core_cmd || core_wr || core_rd) && !core_mute) begin
            while (core_stall) @(posedge clk);
            repeat (ack_dly) @(posedge clk);
            #1 core_ack = 1'b1;
            @(posedge clk); #1 core_ack = 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a strobe or a bus termination.
    initial begin
        logic open, prev;
        logic [2:0] s;
        logic [13:0] es;
        logic [32:0] eb;
        open = 1'b0; prev = 1'b0;
        forever begin
            @(negedge clk);
            s = {core_cmd, core_wr, core_rd};
            if (rst) begin
                open = 1'b0;
            end else begin
                if (s != 3'b0) begin
                    check("strobe_core_idle", {63'b0, open}, 64'd0);
                    check("strobe_gap", {63'b0, prev}, 64'd0);
                    if (sq.size() == 0) check("strobe_expected", 64'(s), 64'd0);
                    else begin
                        es = sq.pop_front();
                        check("strobe_kind", 64'(s), 64'(es[13:11]));
                        if (es[13:11] != RD) check("strobe_din", 64'(core_din), 64'(es[10:0]));
                    end
                    open = 1'b1;
                end
                if (core_ack) open = 1'b0;
                if (wb_ack_o || wb_err_o) begin
                    check("ack_err_exclusive", {63'b0, wb_ack_o & wb_err_o}, 64'd0);
                    if (bq.size() == 0) check("bus_expected", {31'b0, wb_err_o, wb_dat_o}, 64'd0);
                    else begin
                        eb = bq.pop_front();
                        check("bus_resp", {31'b0, wb_err_o, wb_dat_o}, {31'b0, eb});
                    end
                    if (wb_err_o) open = 1'b0;
                end
            end
            prev = s != 3'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {15'b0, wb_ack_o, wb_err_o, wb_irq_o, core_cmd, core_wr, core_rd, core_din, wb_dat_o}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h1, 1);

        ack_dly = 2;
        sq.push_back({CMD, 11'h5A3});
        wb_xfer(2'd0, 1'b1, 32'h5A3, 1'b0, 32'h0, 4);
        wb_xfer(2'd0, 1'b0, 0, 1'b0, 32'h5A3, 1);

        ack_dly = 1;
        core_stall = 1'b1;
        for (int i = 0; i < 4; i++) sq.push_back({WR, 11'h011 + 11'(i)});
        for (int i = 0; i < 5; i++) wb_xfer(2'd1, 1'b1, 32'h11 + i, i == 4, 32'h0, 1);
        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h12, 1);
        core_stall = 1'b0;
        for (int i = 0; i < 200 && sq.size() != 0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check("drain_done", 64'(sq.size()), 64'd0);
        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h1, 1);

        core_dout = 9'h1C4;
        sq.push_back({RD, 11'h0});
        wb_xfer(2'd2, 1'b0, 0, 1'b0, 32'h1C4, 3);

        ack_dly = 3;
        core_dout = 9'h155;
        sq.push_back({WR, 11'h021});
        sq.push_back({RD, 11'h0});
        wb_xfer(2'd1, 1'b1, 32'h21, 1'b0, 32'h0, 1);
        wb_xfer(2'd2, 1'b0, 0, 1'b0, 32'h155, -1);

        core_mute = 1'b1;
        sq.push_back({CMD, 11'h0F0});
        wb_xfer(2'd0, 1'b1, 32'h0F0, 1'b1, 32'h0, TMO + 2);
        core_mute = 1'b0;
        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h41, 1);
        wb_xfer(2'd3, 1'b1, 32'h40, 1'b0, 32'h0, 1);
        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h1, 1);

        wb_xfer(2'd3, 1'b1, 32'h100, 1'b0, 32'h0, 1);
        @(negedge clk);
        check("irq_idle", {63'b0, wb_irq_o}, 64'd0);
        @(posedge clk); #1 core_irq = 1'b1;
        @(posedge clk); #1 core_irq = 1'b0;
        @(negedge clk);
        check("irq_raised", {63'b0, wb_irq_o}, 64'd1);
        @(posedge clk); #1;
        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h121, 1);
        core_irq = 1'b1;
        wb_xfer(2'd3, 1'b1, 32'h120, 1'b0, 32'h0, 1);
        core_irq = 1'b0;
        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h121, 1);
        wb_xfer(2'd3, 1'b1, 32'h120, 1'b0, 32'h0, 1);
        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h101, 1);
        @(negedge clk);
        check("irq_cleared", {63'b0, wb_irq_o}, 64'd0);
        @(posedge clk); #1;

        core_mute = 1'b1;
        sq.push_back({CMD, 11'h03C});
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 2'd0; wb_dat_i = 32'h03C;
        repeat (4) @(posedge clk);
        #1;
        check("din_held_in_wait", 64'(core_din), 64'h03C);
        rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_wait", {15'b0, wb_ack_o, wb_err_o, wb_irq_o, core_cmd, core_wr, core_rd, core_din, wb_dat_o}, 64'd0);
        @(posedge clk); #1 rst = 1'b0; core_mute = 1'b0;
        wb_xfer(2'd0, 1'b0, 0, 1'b0, 32'h0, 1);
        wb_xfer(2'd3, 1'b0, 0, 1'b0, 32'h1, 1);

        repeat (5) @(posedge clk);
        check("bus_queue_empty", 64'(bq.size()), 64'd0);
        check("strobe_queue_empty", 64'(sq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
